// File: rtl/rom_port_arbiter.sv
// Shares one single-port ROM between the fetch port and the load/store port.
// Round-robin on ties; every access costs a grant cycle and a response cycle.
module rom_port_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h0800_0000,
    parameter logic [31:0] SIZE_BYTES = 32'h0010_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    output logic        if_resp_error,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_write,
    input  logic [31:0] d_req_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic        d_resp_error,
    output logic        rom_write_enable,
    output logic [31:0] rom_address,
    output logic [31:0] rom_data_in,
    input  logic [31:0] rom_data_out
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // One past the last window byte, widened so the top of memory cannot wrap
    localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES};

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        port_q, port_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        err_q, err_d;

    logic        win;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_write;
    logic        w_err;

    assign win = (if_req_valid && d_req_valid) ? (last_q == PORT_D ? PORT_IF : PORT_D)
                                               : (d_req_valid ? PORT_D : PORT_IF);
    assign w_addr  = (win == PORT_D) ? d_req_addr : if_req_addr;
    assign w_wdata = (win == PORT_D) ? d_req_wdata : 32'h0;
    assign w_write = (win == PORT_D) && d_req_write;
    assign w_err   = (w_addr[1:0] != 2'b00) || (w_addr < BASE_ADDR)
                  || ({1'b0, w_addr} >= WIN_END);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= PORT_D;
            port_q  <= PORT_IF;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        last_d           = last_q;
        port_d           = port_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        write_d          = write_q;
        err_d            = err_q;
        if_req_ready     = 1'b0;
        d_req_ready      = 1'b0;
        if_resp_valid    = 1'b0;
        if_resp_data     = 32'h0;
        if_resp_error    = 1'b0;
        d_resp_valid     = 1'b0;
        d_resp_data      = 32'h0;
        d_resp_error     = 1'b0;
        rom_write_enable = 1'b0;
        rom_address      = addr_q;
        rom_data_in      = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (!reset && (if_req_valid || d_req_valid)) begin
                    if_req_ready     = (win == PORT_IF);
                    d_req_ready      = (win == PORT_D);
                    rom_address      = w_addr;
                    rom_data_in      = w_wdata;
                    rom_write_enable = w_write && !w_err;
                    last_d           = win;
                    port_d           = win;
                    addr_d           = w_addr;
                    wdata_d          = w_wdata;
                    write_d          = w_write;
                    err_d            = w_err;
                    state_d          = BUSY;
                end
            end
            BUSY: begin
                state_d = IDLE;
                // A reset landing here swallows the pending response
                if (!reset) begin
                    if (port_q == PORT_IF) begin
                        if_resp_valid = 1'b1;
                        if_resp_error = err_q;
                        if_resp_data  = err_q ? 32'h0 : rom_data_out;
                    end else begin
                        d_resp_valid = 1'b1;
                        d_resp_error = err_q;
                        d_resp_data  = (err_q || write_q) ? 32'h0 : rom_data_out;
                    end
                end
            end
        endcase
    end

endmodule
